// File: rtl/cla_sub_8bit_seq.sv
// Sequential carry-lookahead subtractor: diff = a - b - bin, resolved one
// SLICE-bit lookahead slice per cycle, LSB first, behind valid/ready handshakes.
module cla_sub_8bit_seq #(
    parameter int WIDTH = 8,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             state;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   nb_r;
    logic               carry;
    logic [CNT_W-1:0]   cnt;

    logic [SLICE-1:0]   a_s;
    logic [SLICE-1:0]   nb_s;
    logic [SLICE-1:0]   p;
    logic [SLICE-1:0]   g;
    logic [SLICE:0]     c;
    logic [SLICE-1:0]   sum;
    logic [WIDTH-1:0]   diff_next;
    logic               last_slice;

    // Slice select and write-back use constant indices per slice so that the
    // running count only ever drives a compare, never a part-select.
    always_comb begin
        a_s       = '0;
        nb_s      = '0;
        diff_next = diff;
        for (int unsigned s = 0; s < NSLICE; s++) begin
            if (cnt == CNT_W'(s)) begin
                a_s  = a_r[s*SLICE +: SLICE];
                nb_s = nb_r[s*SLICE +: SLICE];
            end
        end
        p    = a_s ^ nb_s;
        g    = a_s & nb_s;
        c    = '0;
        c[0] = carry;
        for (int unsigned i = 0; i < SLICE; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
        sum = p ^ c[SLICE-1:0];
        for (int unsigned s = 0; s < NSLICE; s++) begin
            if (cnt == CNT_W'(s)) begin
                diff_next[s*SLICE +: SLICE] = sum;
            end
        end
        last_slice = (cnt == CNT_W'(NSLICE - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            diff      <= '0;
            bout      <= 1'b0;
            ovf       <= 1'b0;
            cnt       <= '0;
            carry     <= 1'b0;
            a_r       <= '0;
            nb_r      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_r      <= a;
                        nb_r     <= ~b;
                        carry    <= ~bin;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= CALC;
                    end
                end
                CALC: begin
                    diff  <= diff_next;
                    carry <= c[SLICE];
                    cnt   <= cnt + 1'b1;
                    if (last_slice) begin
                        // nb_r holds ~b, so b's sign bit is its complement.
                        bout      <= ~c[SLICE];
                        ovf       <= (a_r[WIDTH-1] ^ ~nb_r[WIDTH-1]) &
                                     (a_r[WIDTH-1] ^ diff_next[WIDTH-1]);
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cla_sub_8bit_seq.sv
// Directed-vector bench for cla_sub_8bit_seq: arithmetic corners, latency,
// back-pressure and mid-operation reset.
module tb_cla_sub_8bit_seq;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] diff;
    logic       bout;
    logic       ovf;

    int total;
    int bad;

    cla_sub_8bit_seq #(.WIDTH(8), .SLICE(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .bin      (bin),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .diff     (diff),
        .bout     (bout),
        .ovf      (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one operation, returns result and accept-to-valid latency,
    // then consumes it so the DUT is back in IDLE.
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb, input logic tbin,
                          output logic [7:0] d, output logic bo, output logic ov,
                          output int lat);
        int w;
        out_ready = 1'b0;
        w = 0;
        while (!in_ready && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        a = ta; b = tb; bin = tbin; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = 8'hAA; b = 8'h55; bin = 1'b1;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        d = diff; bo = bout; ov = ovf;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; bin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (in_ready !== 1'b1)  begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        total++; if (diff !== 8'h00)     begin bad++; $display("FAIL reset_diff got=%h want=00", diff); end
        total++; if ({bout, ovf} !== 2'b00) begin bad++; $display("FAIL reset_flags got=%b%b want=00", bout, ovf); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_vectors();
        logic [7:0] va [6] = '{8'h5A, 8'h00, 8'h80, 8'h7F, 8'h10, 8'h00};
        logic [7:0] vb [6] = '{8'h3C, 8'h01, 8'h01, 8'hFF, 8'h0F, 8'hFF};
        logic       vi [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [7:0] ed [6] = '{8'h1E, 8'hFF, 8'h7F, 8'h80, 8'h00, 8'h00};
        logic       eb [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic       eo [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [7:0] d;
        logic bo, ov;
        int lat;
        for (int i = 0; i < 6; i++) begin
            run_op(va[i], vb[i], vi[i], d, bo, ov, lat);
            total++; if (lat !== 2)     begin bad++; $display("FAIL vec%0d_latency got=%0d want=2", i, lat); end
            total++; if (d !== ed[i])   begin bad++; $display("FAIL vec%0d_diff got=%h want=%h", i, d, ed[i]); end
            total++; if (bo !== eb[i])  begin bad++; $display("FAIL vec%0d_bout got=%b want=%b", i, bo, eb[i]); end
            total++; if (ov !== eo[i])  begin bad++; $display("FAIL vec%0d_ovf got=%b want=%b", i, ov, eo[i]); end
            total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL vec%0d_idle_ready got=%b want=1", i, in_ready); end
        end
    endtask

    task automatic test_back_pressure();
        int w;
        // 0xA5 - 0x21 = 0x84, no borrow, no signed overflow
        out_ready = 1'b0;
        a = 8'hA5; b = 8'h21; bin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        a = 8'h44; b = 8'h04; bin = 1'b0;
        w = 0;
        while (!out_valid && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        total++; if (w !== 2) begin bad++; $display("FAIL bp_latency got=%0d want=2", w); end
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            total++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || diff !== 8'h84 || bout !== 1'b0 || ovf !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold%0d got v=%b r=%b d=%h b=%b o=%b want v=1 r=0 d=84 b=0 o=0",
                         k, out_valid, in_ready, diff, bout, ovf);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL bp_release got v=%b r=%b want v=0 r=1", out_valid, in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_accept got r=%b want r=0", in_ready); end
        repeat (2) @(posedge clk);
        #1;
        total++; if (out_valid !== 1'b1 || diff !== 8'h40 || bout !== 1'b0 || ovf !== 1'b0) begin
            bad++; $display("FAIL bp_next got v=%b d=%h b=%b o=%b want v=1 d=40 b=0 o=0", out_valid, diff, bout, ovf);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_op();
        logic [7:0] d;
        logic bo, ov;
        int lat;
        // 0xFF - 0x01: slice 0 leaves diff low nibble = E before reset hits
        a = 8'hFF; b = 8'h01; bin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        total++; if (diff[3:0] !== 4'hE) begin bad++; $display("FAIL rst_partial got=%h want=e", diff[3:0]); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || diff !== 8'h00 || bout !== 1'b0 || ovf !== 1'b0) begin
            bad++; $display("FAIL rst_async got r=%b v=%b d=%h b=%b o=%b want r=1 v=0 d=00 b=0 o=0",
                            in_ready, out_valid, diff, bout, ovf);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_no_valid%0d got=%b want=0", k, out_valid); end
        end
        run_op(8'h33, 8'h11, 1'b0, d, bo, ov, lat);
        total++; if (lat !== 2 || d !== 8'h22 || bo !== 1'b0 || ov !== 1'b0) begin
            bad++; $display("FAIL rst_after_op got lat=%0d d=%h b=%b o=%b want lat=2 d=22 b=0 o=0", lat, d, bo, ov);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_vectors();
        test_back_pressure();
        test_reset_mid_op();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
